// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - instruction-memory and decode-side signal bundle for the fetch sequencer
interface imem_fetch_ctrl_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output fault
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  fault
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - fetch PC sequencer with one-cycle memory latency tracking and 2-entry output queue
module imem_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned MEM_SIZE = 4095
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_fetch_ctrl_if.master     bus
);

    localparam logic [64:0] LAST_BYTE = 65'(MEM_SIZE) - 65'd1;

    logic [63:0] fetch_pc;
    logic        inflight_valid;
    logic [63:0] inflight_pc;

    logic [63:0] head_pc;
    logic [31:0] head_instr;
    logic [63:0] tail_pc;
    logic [31:0] tail_instr;
    logic [1:0]  count;
    logic        fault_q;

    logic        redirect;
    logic        pc_bad;
    logic        out_valid_int;
    logic        pop;
    logic        push;
    logic [1:0]  occupancy;
    logic        space_ok;
    logic        issue;
    logic        fault_set;

    always_comb begin
        redirect      = bus.redirect_valid;
        // 65-bit sum so a PC near the top of the address space cannot wrap into range
        pc_bad        = (fetch_pc[1:0] != 2'b00) || (({1'b0, fetch_pc} + 65'd3) > LAST_BYTE);
        out_valid_int = (count != 2'd0) && !redirect;
        pop           = out_valid_int && bus.out_ready;
        push          = inflight_valid && !redirect;
        // Entries held after this edge if nothing new is issued; issue only when one slot stays free
        occupancy     = count - {1'b0, pop} + {1'b0, inflight_valid};
        space_ok      = (occupancy < 2'd2);
        issue         = !redirect && !fault_q && !pc_bad && space_ok;
        fault_set     = !redirect && !fault_q &&  pc_bad && space_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc       <= RESET_PC;
            inflight_valid <= 1'b0;
            inflight_pc    <= 64'h0;
            fault_q        <= 1'b0;
        end else if (redirect) begin
            fetch_pc       <= bus.redirect_pc;
            inflight_valid <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            inflight_valid <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 64'd4;
            end
            if (fault_set) begin
                fault_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            head_pc    <= 64'h0;
            head_instr <= 32'h0;
            tail_pc    <= 64'h0;
            tail_instr <= 32'h0;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc    <= inflight_pc;
                        head_instr <= bus.imem_instr;
                    end else begin
                        tail_pc    <= inflight_pc;
                        tail_instr <= bus.imem_instr;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_pc    <= tail_pc;
                    head_instr <= tail_instr;
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_pc    <= inflight_pc;
                        head_instr <= bus.imem_instr;
                    end else begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                        tail_pc    <= inflight_pc;
                        tail_instr <= bus.imem_instr;
                    end
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

    always_comb begin
        bus.imem_addr = fetch_pc;
        bus.out_valid = out_valid_int;
        bus.out_pc    = (count != 2'd0) ? head_pc    : 64'h0;
        bus.out_instr = (count != 2'd0) ? head_instr : 32'h0;
        bus.fault     = fault_q;
    end

endmodule
